// File: rtl/dm_access_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dm_access_ctrl : data-memory access sequencer, CPU/aux arbitration,       |
// | byte-lane steering and load alignment. Optional aux port: AUX_PORT_EN.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dm_access_ctrl #(
  parameter int ADDR_W     = 12,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_dmop,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_align_err,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [31:0]       aux_addr,
  input  logic [31:0]       aux_wdata,
  output logic              aux_ack,
  output logic [31:0]       aux_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    ERR    = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic              owner_aux, owner_aux_nxt;
  logic              lat_we, lat_we_nxt;
  logic [1:0]        lat_off, lat_off_nxt;
  logic [1:0]        lat_dmop, lat_dmop_nxt;
  logic              mem_en_nxt;
  logic [3:0]        mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [31:0]       mem_wdata_nxt;
  logic              cpu_ack_nxt, aux_ack_nxt, cpu_align_err_nxt;
  logic              aux_win;
  logic              cpu_misalign;
  logic [3:0]        cpu_be;
  logic [31:0]       cpu_wrepl;
  logic [31:0]       rd_shifted;
  logic              unused_bits;

  assign unused_bits = ^{aux_req, aux_addr[1:0], aux_addr[31:ADDR_W+2], cpu_addr[31:ADDR_W+2]};

`ifdef AUX_PORT_EN
  localparam int CNT_W = $clog2(STARVE_LIM + 1);
  logic [CNT_W-1:0] starve_cnt;

  assign aux_win = aux_req && (!cpu_req || starve_cnt == CNT_W'(STARVE_LIM));

  // Counts CPU grants that bypassed a waiting aux request.
  always_ff @(posedge clk) begin
    if (reset)                          starve_cnt <= '0;
    else if (!aux_req)                  starve_cnt <= '0;
    else if (state == IDLE && aux_win)  starve_cnt <= '0;
    else if (state == IDLE && cpu_req)  starve_cnt <= starve_cnt + 1'b1;
  end

  assign aux_rdata = (state == RESP && owner_aux) ? mem_rdata : 32'h0;
`else
  assign aux_win   = 1'b0;
  assign aux_rdata = 32'h0;
`endif

  assign cpu_misalign = (cpu_dmop == 2'b11) ||
                        (cpu_dmop == 2'b01 && cpu_addr[0]) ||
                        (cpu_dmop == 2'b10 && cpu_addr[1:0] != 2'b00);

  always_comb begin
    cpu_be    = 4'b1111;
    cpu_wrepl = cpu_wdata;
    case (cpu_dmop)
      2'b00: begin
        cpu_be    = 4'b0001 << cpu_addr[1:0];
        cpu_wrepl = {4{cpu_wdata[7:0]}};
      end
      2'b01: begin
        cpu_be    = cpu_addr[1] ? 4'b1100 : 4'b0011;
        cpu_wrepl = {2{cpu_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt         = state;
    owner_aux_nxt     = owner_aux;
    lat_we_nxt        = lat_we;
    lat_off_nxt       = lat_off;
    lat_dmop_nxt      = lat_dmop;
    mem_en_nxt        = 1'b0;
    mem_we_nxt        = 4'b0000;
    mem_addr_nxt      = '0;
    mem_wdata_nxt     = 32'h0;
    cpu_ack_nxt       = 1'b0;
    aux_ack_nxt       = 1'b0;
    cpu_align_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (aux_win) begin
          owner_aux_nxt = 1'b1;
          lat_we_nxt    = aux_we;
          lat_off_nxt   = 2'b00;
          lat_dmop_nxt  = 2'b10;
          state_nxt     = ACCESS;
          mem_en_nxt    = 1'b1;
          mem_addr_nxt  = aux_addr[ADDR_W+1:2];
          mem_we_nxt    = aux_we ? 4'b1111 : 4'b0000;
          mem_wdata_nxt = aux_we ? aux_wdata : 32'h0;
          aux_ack_nxt   = aux_we;
        end else if (cpu_req) begin
          owner_aux_nxt = 1'b0;
          lat_we_nxt    = cpu_we;
          lat_off_nxt   = cpu_addr[1:0];
          lat_dmop_nxt  = cpu_dmop;
          if (cpu_misalign) begin
            state_nxt         = ERR;
            cpu_ack_nxt       = 1'b1;
            cpu_align_err_nxt = 1'b1;
          end else begin
            state_nxt     = ACCESS;
            mem_en_nxt    = 1'b1;
            mem_addr_nxt  = cpu_addr[ADDR_W+1:2];
            mem_we_nxt    = cpu_we ? cpu_be : 4'b0000;
            mem_wdata_nxt = cpu_we ? cpu_wrepl : 32'h0;
            cpu_ack_nxt   = cpu_we;
          end
        end
      end
      ACCESS: begin
        // Stores were acked on entry; loads wait one cycle for read data.
        if (lat_we) begin
          state_nxt = IDLE;
        end else begin
          state_nxt   = RESP;
          cpu_ack_nxt = !owner_aux;
          aux_ack_nxt = owner_aux;
        end
      end
      RESP:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      owner_aux     <= 1'b0;
      lat_we        <= 1'b0;
      lat_off       <= 2'b00;
      lat_dmop      <= 2'b00;
      mem_en        <= 1'b0;
      mem_we        <= 4'b0000;
      mem_addr      <= '0;
      mem_wdata     <= 32'h0;
      cpu_ack       <= 1'b0;
      aux_ack       <= 1'b0;
      cpu_align_err <= 1'b0;
    end else begin
      state         <= state_nxt;
      owner_aux     <= owner_aux_nxt;
      lat_we        <= lat_we_nxt;
      lat_off       <= lat_off_nxt;
      lat_dmop      <= lat_dmop_nxt;
      mem_en        <= mem_en_nxt;
      mem_we        <= mem_we_nxt;
      mem_addr      <= mem_addr_nxt;
      mem_wdata     <= mem_wdata_nxt;
      cpu_ack       <= cpu_ack_nxt;
      aux_ack       <= aux_ack_nxt;
      cpu_align_err <= cpu_align_err_nxt;
    end
  end

  assign rd_shifted = mem_rdata >> {lat_off, 3'b000};

  always_comb begin
    cpu_rdata = 32'h0;
    if (state == RESP && !owner_aux) begin
      case (lat_dmop)
        2'b00:   cpu_rdata = {24'h0, rd_shifted[7:0]};
        2'b01:   cpu_rdata = {16'h0, rd_shifted[15:0]};
        default: cpu_rdata = rd_shifted;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dm_access_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dm_access_ctrl : directed self-checking bench for dm_access_ctrl.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_dm_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [1:0]  cpu_dmop;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_ack, cpu_align_err;
  logic [31:0] cpu_rdata;
  logic        aux_req, aux_we;
  logic [31:0] aux_addr, aux_wdata;
  logic        aux_ack;
  logic [31:0] aux_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_access_ctrl #(.ADDR_W(12), .STARVE_LIM(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_dmop(cpu_dmop), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .cpu_align_err(cpu_align_err),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_ack(aux_ack), .aux_rdata(aux_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Single-port synchronous RAM, read-before-write, 1-cycle read latency.
  logic [31:0] ram [0:15];
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= ram[mem_addr[3:0]];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr[3:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_op(input logic we, input logic [1:0] dmop, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat);
    cpu_req = 1'b1; cpu_we = we; cpu_dmop = dmop; cpu_addr = addr; cpu_wdata = wdata;
    lat = 0; rdata = 32'h0; err = 1'b0;
    do begin tick(); lat++; end while (!cpu_ack && lat < 10);
    rdata = cpu_rdata;
    err   = cpu_align_err;
    cpu_req = 1'b0;
    tick();
  endtask

`ifdef AUX_PORT_EN
  task automatic aux_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output int lat);
    aux_req = 1'b1; aux_we = we; aux_addr = addr; aux_wdata = wdata;
    lat = 0; rdata = 32'h0;
    do begin tick(); lat++; end while (!aux_ack && lat < 10);
    rdata = aux_rdata;
    aux_req = 1'b0;
    tick();
  endtask
`endif

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got %0b exp 0", mem_en); end
    checks++; if (mem_we !== 4'h0) begin errors++; $display("FAIL reset_mem_we got %h exp 0", mem_we); end
    checks++; if (mem_addr !== 12'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got %h exp 0", mem_wdata); end
    checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_cpu_ack got %0b exp 0", cpu_ack); end
    checks++; if (aux_ack !== 1'b0) begin errors++; $display("FAIL reset_aux_ack got %0b exp 0", aux_ack); end
    checks++; if (cpu_align_err !== 1'b0) begin errors++; $display("FAIL reset_align_err got %0b exp 0", cpu_align_err); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_cpu_rdata got %h exp 0", cpu_rdata); end
    checks++; if (aux_rdata !== 32'h0) begin errors++; $display("FAIL reset_aux_rdata got %h exp 0", aux_rdata); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_store_byte();
    logic [31:0] rd; logic er; int lat;
    cpu_op(1'b1, 2'b10, 32'h10, 32'h0, rd, er, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL sw_latency got %0d exp 1", lat); end
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_dmop = 2'b00; cpu_addr = 32'h13; cpu_wdata = 32'hAB;
    tick();
    checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL sb_mem_en got %0b exp 1", mem_en); end
    checks++; if (mem_we !== 4'b1000) begin errors++; $display("FAIL sb_mem_we got %b exp 1000", mem_we); end
    checks++; if (mem_addr !== 12'd4) begin errors++; $display("FAIL sb_mem_addr got %h exp 4", mem_addr); end
    checks++; if (mem_wdata !== 32'hABABABAB) begin errors++; $display("FAIL sb_mem_wdata got %h exp ababab ab", mem_wdata); end
    checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL sb_cpu_ack got %0b exp 1", cpu_ack); end
    cpu_req = 1'b0;
    tick();
    checks++; if (mem_en !== 1'b0 || cpu_ack !== 1'b0) begin errors++; $display("FAIL sb_after en=%0b ack=%0b exp 0 0", mem_en, cpu_ack); end
  endtask

  task automatic test_store_half();
    logic [31:0] rd; logic er; int lat;
    cpu_op(1'b1, 2'b10, 32'h08, 32'h0, rd, er, lat);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_dmop = 2'b01; cpu_addr = 32'h0A; cpu_wdata = 32'h1234BEEF;
    tick();
    checks++; if (mem_we !== 4'b1100) begin errors++; $display("FAIL sh_mem_we got %b exp 1100", mem_we); end
    checks++; if (mem_wdata !== 32'hBEEFBEEF) begin errors++; $display("FAIL sh_mem_wdata got %h exp beefbeef", mem_wdata); end
    checks++; if (mem_addr !== 12'd2) begin errors++; $display("FAIL sh_mem_addr got %h exp 2", mem_addr); end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_load();
    logic [31:0] rd; logic er; int lat;
    cpu_op(1'b1, 2'b10, 32'h04, 32'h12345678, rd, er, lat);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_dmop = 2'b01; cpu_addr = 32'h06; cpu_wdata = 32'h0;
    tick();
    checks++; if (mem_en !== 1'b1 || mem_we !== 4'b0000 || mem_addr !== 12'd1) begin errors++; $display("FAIL lh_access en=%0b we=%b addr=%h exp 1 0000 1", mem_en, mem_we, mem_addr); end
    checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL lh_early_ack got %0b exp 0", cpu_ack); end
    tick();
    checks++; if (cpu_ack !== 1'b1 || mem_en !== 1'b0) begin errors++; $display("FAIL lh_resp ack=%0b en=%0b exp 1 0", cpu_ack, mem_en); end
    checks++; if (cpu_rdata !== 32'h00001234) begin errors++; $display("FAIL lh_rdata got %h exp 00001234", cpu_rdata); end
    cpu_req = 1'b0;
    tick();
    cpu_op(1'b0, 2'b00, 32'h05, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h56 || lat !== 2) begin errors++; $display("FAIL lb5 got %h lat %0d exp 00000056 lat 2", rd, lat); end
    cpu_op(1'b0, 2'b00, 32'h07, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h12) begin errors++; $display("FAIL lb7 got %h exp 00000012", rd); end
    cpu_op(1'b0, 2'b01, 32'h04, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h5678) begin errors++; $display("FAIL lh4 got %h exp 00005678", rd); end
    cpu_op(1'b0, 2'b10, 32'h04, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL lw4 got %h exp 12345678", rd); end
    cpu_op(1'b0, 2'b10, 32'h10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hAB000000) begin errors++; $display("FAIL lw_after_sb got %h exp ab000000", rd); end
    cpu_op(1'b0, 2'b10, 32'h08, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hBEEF0000) begin errors++; $display("FAIL lw_after_sh got %h exp beef0000", rd); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic er; int lat;
    cpu_op(1'b1, 2'b10, 32'h00, 32'h55AA55AA, rd, er, lat);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_dmop = 2'b10; cpu_addr = 32'h02; cpu_wdata = 32'hFFFFFFFF;
    tick();
    checks++; if (mem_en !== 1'b0 || mem_we !== 4'b0000) begin errors++; $display("FAIL sw_mis_mem en=%0b we=%b exp 0 0000", mem_en, mem_we); end
    checks++; if (cpu_ack !== 1'b1 || cpu_align_err !== 1'b1) begin errors++; $display("FAIL sw_mis_err ack=%0b err=%0b exp 1 1", cpu_ack, cpu_align_err); end
    cpu_req = 1'b0;
    tick();
    checks++; if (cpu_ack !== 1'b0 || cpu_align_err !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL sw_mis_after ack=%0b err=%0b en=%0b exp 0 0 0", cpu_ack, cpu_align_err, mem_en); end
    cpu_op(1'b0, 2'b01, 32'h01, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b1 || lat !== 1) begin errors++; $display("FAIL lh1_err err=%0b lat=%0d exp 1 1", er, lat); end
    cpu_op(1'b1, 2'b01, 32'h03, 32'hFFFF, rd, er, lat);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL sh3_err got %0b exp 1", er); end
    cpu_op(1'b1, 2'b11, 32'h00, 32'hFFFFFFFF, rd, er, lat);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL dmop11_err got %0b exp 1", er); end
    cpu_op(1'b0, 2'b00, 32'h03, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b0 || rd !== 32'h55) begin errors++; $display("FAIL lb3 err=%0b rd=%h exp 0 00000055", er, rd); end
    cpu_op(1'b0, 2'b01, 32'h02, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b0 || rd !== 32'h55AA) begin errors++; $display("FAIL lh2 err=%0b rd=%h exp 0 000055aa", er, rd); end
    cpu_op(1'b0, 2'b10, 32'h00, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h55AA55AA) begin errors++; $display("FAIL mis_no_write got %h exp 55aa55aa", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_dmop = 2'b10; cpu_addr = 32'h18; cpu_wdata = 32'hCAFEF00D;
    tick();
    checks++; if (cpu_ack !== 1'b1 || mem_addr !== 12'd6) begin errors++; $display("FAIL b2b_first ack=%0b addr=%h exp 1 6", cpu_ack, mem_addr); end
    cpu_addr = 32'h1C; cpu_wdata = 32'h0BADBEEF;
    tick();
    checks++; if (cpu_ack !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL b2b_gap ack=%0b en=%0b exp 0 0", cpu_ack, mem_en); end
    tick();
    checks++; if (cpu_ack !== 1'b1 || mem_addr !== 12'd7 || mem_wdata !== 32'h0BADBEEF) begin errors++; $display("FAIL b2b_second ack=%0b addr=%h wd=%h exp 1 7 0badbeef", cpu_ack, mem_addr, mem_wdata); end
    cpu_req = 1'b0;
    tick();
    cpu_op(1'b0, 2'b10, 32'h18, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_rd6 got %h exp cafef00d", rd); end
    cpu_op(1'b0, 2'b10, 32'h1C, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0BADBEEF) begin errors++; $display("FAIL b2b_rd7 got %h exp 0badbeef", rd); end
  endtask

  task automatic test_arbitration();
    int n = 0;
    int cyc = 0;
    int caux = 0;
    int ccpu = 0;
    logic [9:0] order = '0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_dmop = 2'b10; cpu_addr = 32'h20; cpu_wdata = 32'h11111111;
    aux_req = 1'b1; aux_we = 1'b1; aux_addr = 32'h24; aux_wdata = 32'h22222222;
`ifdef AUX_PORT_EN
    while (n < 10 && cyc < 40) begin
      tick(); cyc++;
      if (cpu_ack && n < 10) begin order[n] = 1'b0; n++; end
      if (aux_ack && n < 10) begin order[n] = 1'b1; n++; end
    end
    cpu_req = 1'b0; aux_req = 1'b0;
    checks++; if (n !== 10) begin errors++; $display("FAIL arb_grants got %0d exp 10", n); end
    checks++; if (order !== 10'b1000010000) begin errors++; $display("FAIL arb_order got %b exp 1000010000 (bit0 first, 1=aux)", order); end
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cpu_ack) ccpu++;
      if (aux_ack) caux++;
    end
    cpu_req = 1'b0; aux_req = 1'b0;
    checks++; if (ccpu !== 10) begin errors++; $display("FAIL noaux_cpu_acks got %0d exp 10", ccpu); end
    checks++; if (caux !== 0) begin errors++; $display("FAIL noaux_aux_acks got %0d exp 0", caux); end
`endif
    tick(); tick();
  endtask

`ifdef AUX_PORT_EN
  task automatic test_aux_port();
    logic [31:0] rd; logic er; int lat;
    aux_op(1'b0, 32'h07, 32'h0, rd, lat);
    checks++; if (rd !== 32'h12345678 || lat !== 2) begin errors++; $display("FAIL aux_load rd=%h lat=%0d exp 12345678 2", rd, lat); end
    aux_op(1'b1, 32'h2B, 32'hA5A5C3C3, rd, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL aux_store_lat got %0d exp 1", lat); end
    cpu_op(1'b0, 2'b10, 32'h28, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hA5A5C3C3) begin errors++; $display("FAIL aux_store_rd got %h exp a5a5c3c3", rd); end
  endtask
`endif

  task automatic test_reset_mid_access();
    logic [31:0] rd; logic er; int lat;
    logic stray = 1'b0;
`ifdef AUX_PORT_EN
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 32'h04; aux_wdata = 32'h0;
`else
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_dmop = 2'b10; cpu_addr = 32'h04; cpu_wdata = 32'h0;
`endif
    tick();
    checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL rst_mid_access en got %0b exp 1", mem_en); end
    reset = 1'b1;
    tick();
    checks++; if (mem_en !== 1'b0 || aux_ack !== 1'b0 || cpu_ack !== 1'b0) begin errors++; $display("FAIL rst_mid en=%0b aack=%0b cack=%0b exp 0 0 0", mem_en, aux_ack, cpu_ack); end
    reset = 1'b0; aux_req = 1'b0; cpu_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (aux_ack || cpu_ack) stray = 1'b1;
    end
    checks++; if (stray !== 1'b0) begin errors++; $display("FAIL rst_mid_stray_ack got %0b exp 0", stray); end
`ifdef AUX_PORT_EN
    aux_op(1'b0, 32'h04, 32'h0, rd, lat);
`else
    cpu_op(1'b0, 2'b10, 32'h04, 32'h0, rd, er, lat);
`endif
    checks++; if (rd !== 32'h12345678 || lat !== 2) begin errors++; $display("FAIL rst_mid_reissue rd=%h lat=%0d exp 12345678 2", rd, lat); end
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_dmop = 2'b00; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    aux_req = 1'b0; aux_we = 1'b0; aux_addr = 32'h0; aux_wdata = 32'h0;
    test_reset();
    test_store_byte();
    test_store_half();
    test_load();
    test_misaligned();
    test_back_to_back();
    test_arbitration();
`ifdef AUX_PORT_EN
    test_aux_port();
`endif
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
